free_list: RTL and testbench

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list_pkg.sv | 11 +
 rtl/free_list.sv | 164 ++++++++++++++++
 tb/tb_free_list.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/free_list_pkg.sv
// Shared rename-stage types: register-file sizing and the physical register tag.
// Used by free_list, rename and rob.
package free_list_pkg;

  localparam int unsigned NUM_PREGS = 64;
  localparam int unsigned NUM_AREGS = 32;
  localparam int unsigned PREG_W    = 6;

  typedef logic [PREG_W-1:0] preg_t;

endpackage

// File: rtl/free_list.sv
// Physical register free list: circular FIFO of NUM_PREGS-NUM_AREGS tags.
// Two allocation slots pop at head with zero-cycle latency (all-or-nothing);
// two retire slots push at tail, visible to allocation from the next cycle.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   alloc_req_1/2                 rename slot needs a destination register
//   alloc_pd_1/2, alloc_valid_1/2 granted register tag and grant strobe (comb)
//   stall                         requested allocation cannot be satisfied (comb)
//   reg_free_1/2, free_valid_1/2  registers released by ROB retire (p0 ignored)
//   err_double_free               sticky free-list misuse flag (FREE_LIST_CHECK_EN only)
//   count                         number of free entries held
//
// Build option: define FREE_LIST_CHECK_EN to add the free-vector checker.
module free_list
  import free_list_pkg::*;
#(
  parameter int unsigned NUM_PREGS = free_list_pkg::NUM_PREGS,
  parameter int unsigned NUM_AREGS = free_list_pkg::NUM_AREGS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_req_1,
  input  logic       alloc_req_2,
  output logic [5:0] alloc_pd_1,
  output logic [5:0] alloc_pd_2,
  output logic       alloc_valid_1,
  output logic       alloc_valid_2,
  output logic       stall,
  input  logic [5:0] reg_free_1,
  input  logic       free_valid_1,
  input  logic [5:0] reg_free_2,
  input  logic       free_valid_2,
`ifdef FREE_LIST_CHECK_EN
  output logic       err_double_free,
`endif
  output logic [5:0] count
);

  localparam int unsigned DEPTH   = NUM_PREGS - NUM_AREGS;
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0]  DEPTH_C = 7'(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;

  // Pointer increment modulo DEPTH (DEPTH need not be a power of two).
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  preg_t      entries [DEPTH];
  ptr_t       head;
  ptr_t       tail;
  ptr_t       head_p1;
  ptr_t       tail_p1;
  ptr_t       head_nxt;
  ptr_t       tail_nxt;
  logic [1:0] req_pops;
  logic [1:0] pops;
  logic       push_1;
  logic       push_2;
  logic       acc_1;
  logic       acc_2;
  logic [6:0] cnt_after_pop;
  logic [6:0] cnt_after_1;
  logic [6:0] cnt_nxt;

  // Allocation side: grants come straight from registered head/count.
  always_comb begin
    head_p1       = ptr_inc(head);
    req_pops      = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
    stall         = {5'b0, req_pops} > {1'b0, count};
    alloc_valid_1 = alloc_req_1 & ~stall;
    alloc_valid_2 = alloc_req_2 & ~stall;
    alloc_pd_1    = entries[head];
    // A lone slot-2 request takes the head entry.
    alloc_pd_2    = (alloc_req_2 && !alloc_req_1) ? entries[head] : entries[head_p1];
    pops          = stall ? 2'd0 : req_pops;
  end

  // Free side: slot 1 pushes before slot 2; pushes beyond DEPTH are dropped.
  always_comb begin
    tail_p1       = ptr_inc(tail);
    push_1        = free_valid_1 && (reg_free_1 != '0);
    push_2        = free_valid_2 && (reg_free_2 != '0);
    cnt_after_pop = {1'b0, count} - {5'b0, pops};
    acc_1         = push_1 && (cnt_after_pop < DEPTH_C);
    cnt_after_1   = cnt_after_pop + {6'b0, acc_1};
    acc_2         = push_2 && (cnt_after_1 < DEPTH_C);
    cnt_nxt       = cnt_after_1 + {6'b0, acc_2};
  end

  // Next pointers advance by the number of accepted pops/pushes.
  always_comb begin
    head_nxt = head;
    tail_nxt = tail;
    case (pops)
      2'd1:    head_nxt = head_p1;
      2'd2:    head_nxt = ptr_inc(head_p1);
      default: head_nxt = head;
    endcase
    case ({acc_1, acc_2})
      2'b10,
      2'b01:   tail_nxt = tail_p1;
      2'b11:   tail_nxt = ptr_inc(tail_p1);
      default: tail_nxt = tail;
    endcase
  end

  // FIFO state; reset reloads the list with every non-architectural register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 6'(DEPTH);
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries[i] <= preg_t'(NUM_AREGS + 32'(i));
      end
    end else begin
      head  <= head_nxt;
      tail  <= tail_nxt;
      count <= 6'(cnt_nxt);
      if (acc_1) begin
        entries[tail] <= reg_free_1;
      end
      if (acc_2) begin
        entries[acc_1 ? tail_p1 : tail] <= reg_free_2;
      end
    end
  end

`ifdef FREE_LIST_CHECK_EN
  // Free-vector shadow of list membership, used only to flag misuse.
  logic [NUM_PREGS-1:0] free_vec;
  logic [NUM_PREGS-1:0] free_vec_nxt;
  logic                 misuse;

  always_comb begin
    free_vec_nxt = free_vec;
    if (alloc_valid_1) free_vec_nxt[alloc_pd_1] = 1'b0;
    if (alloc_valid_2) free_vec_nxt[alloc_pd_2] = 1'b0;
    if (acc_1)         free_vec_nxt[reg_free_1] = 1'b1;
    if (acc_2)         free_vec_nxt[reg_free_2] = 1'b1;
    misuse = (push_1 && free_vec[reg_free_1])
           || (push_2 && free_vec[reg_free_2])
           || (push_1 && push_2 && (reg_free_1 == reg_free_2))
           || (push_1 && !acc_1)
           || (push_2 && !acc_2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_double_free <= 1'b0;
      for (int i = 0; i < int'(NUM_PREGS); i++) begin
        free_vec[i] <= (32'(i) >= NUM_AREGS);
      end
    end else begin
      err_double_free <= err_double_free | misuse;
      free_vec        <= free_vec_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed testbench for free_list: reset state, dual/single allocation,
// stall, same-cycle free without bypass, FIFO order, wrap, p0 frees,
// overflow saturation, asynchronous mid-stream reset, optional checker.
module tb_free_list;

  logic       clk;
  logic       rst;
  logic       alloc_req_1;
  logic       alloc_req_2;
  logic [5:0] alloc_pd_1;
  logic [5:0] alloc_pd_2;
  logic       alloc_valid_1;
  logic       alloc_valid_2;
  logic       stall;
  logic [5:0] reg_free_1;
  logic       free_valid_1;
  logic [5:0] reg_free_2;
  logic       free_valid_2;
  logic [5:0] count;
`ifdef FREE_LIST_CHECK_EN
  logic       err_double_free;
`endif

  int checks   = 0;
  int failures = 0;

  free_list dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_req_1   (alloc_req_1),
    .alloc_req_2   (alloc_req_2),
    .alloc_pd_1    (alloc_pd_1),
    .alloc_pd_2    (alloc_pd_2),
    .alloc_valid_1 (alloc_valid_1),
    .alloc_valid_2 (alloc_valid_2),
    .stall         (stall),
    .reg_free_1    (reg_free_1),
    .free_valid_1  (free_valid_1),
    .reg_free_2    (reg_free_2),
    .free_valid_2  (free_valid_2),
`ifdef FREE_LIST_CHECK_EN
    .err_double_free (err_double_free),
`endif
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Apply inputs just after a rising edge, then move to mid-cycle for sampling.
  task automatic drive(input logic r1, input logic r2,
                       input logic v1, input logic [5:0] f1,
                       input logic v2, input logic [5:0] f2);
    alloc_req_1  = r1;
    alloc_req_2  = r2;
    free_valid_1 = v1;
    reg_free_1   = f1;
    free_valid_2 = v2;
    reg_free_2   = f2;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_pairs [10] = '{34, 35, 36, 37, 38, 39, 42, 43, 45, 46};

  initial begin
    rst = 1'b1;
    alloc_req_1 = 1'b0; alloc_req_2 = 1'b0;
    free_valid_1 = 1'b0; reg_free_1 = '0;
    free_valid_2 = 1'b0; reg_free_2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    drive(0, 0, 0, 0, 0, 0);
    check("rst_pd1", 32'(alloc_pd_1), 32);
    check("rst_pd2", 32'(alloc_pd_2), 33);
    check("rst_stall", 32'(stall), 0);
    check("rst_v1", 32'(alloc_valid_1), 0);
    check("rst_v2", 32'(alloc_valid_2), 0);
    check("rst_count", 32'(count), 32);
    tick();

    // First dual allocation
    drive(1, 1, 0, 0, 0, 0);
    check("dual_v1", 32'(alloc_valid_1), 1);
    check("dual_v2", 32'(alloc_valid_2), 1);
    check("dual_pd1", 32'(alloc_pd_1), 32);
    check("dual_pd2", 32'(alloc_pd_2), 33);
    check("dual_stall", 32'(stall), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("dual_count", 32'(count), 30);
    check("dual_next_pd1", 32'(alloc_pd_1), 34);
    tick();

    // Drain the list with 15 more dual allocations
    for (int k = 0; k < 15; k++) begin
      drive(1, 1, 0, 0, 0, 0);
      check("drain_pd1", 32'(alloc_pd_1), 32'(34 + 2 * k));
      check("drain_pd2", 32'(alloc_pd_2), 32'(35 + 2 * k));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    check("empty_count", 32'(count), 0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    check("empty_stall", 32'(stall), 1);
    check("empty_v1", 32'(alloc_valid_1), 0);
    check("empty_v2", 32'(alloc_valid_2), 0);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    check("empty_count_hold", 32'(count), 0);
    check("empty_stall2", 32'(stall), 1);
    check("empty_v2b", 32'(alloc_valid_2), 0);
    tick();

    // Free without bypass: stall this cycle, grant p40 next cycle
    drive(1, 0, 1, 40, 0, 0);
    check("nobyp_stall", 32'(stall), 1);
    check("nobyp_v1", 32'(alloc_valid_1), 0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    check("nobyp_count", 32'(count), 1);
    check("nobyp_stall_next", 32'(stall), 0);
    check("nobyp_v1_next", 32'(alloc_valid_1), 1);
    check("nobyp_pd1_next", 32'(alloc_pd_1), 40);
    tick();

    // Slot-2 free alone, then slot-2 request alone takes head
    drive(0, 0, 0, 0, 1, 41);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    check("r2only_v2", 32'(alloc_valid_2), 1);
    check("r2only_v1", 32'(alloc_valid_1), 0);
    check("r2only_pd2", 32'(alloc_pd_2), 41);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("r2only_count", 32'(count), 0);
    tick();

    // Fill to 10, then dual alloc + dual free together
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 6'(32 + 2 * k), 1, 6'(33 + 2 * k));
      tick();
    end
    drive(0, 0, 1, 42, 1, 43);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("fill10_count", 32'(count), 10);
    tick();
    drive(1, 1, 1, 45, 1, 46);
    check("mix_pd1", 32'(alloc_pd_1), 32);
    check("mix_pd2", 32'(alloc_pd_2), 33);
    check("mix_v", 32'({alloc_valid_1, alloc_valid_2}), 3);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("mix_count", 32'(count), 10);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 0, 0, 0, 0);
      check("order_pd1", 32'(alloc_pd_1), 32'(exp_pairs[2 * k]));
      check("order_pd2", 32'(alloc_pd_2), 32'(exp_pairs[2 * k + 1]));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    check("order_count", 32'(count), 0);
    tick();

    // Wrap: 40 alloc/free pairs at count 1
    drive(0, 0, 1, 50, 0, 0);
    tick();
    for (int k = 0; k < 40; k++) begin
      drive(1, 0, 1, 6'(k + 1), 0, 0);
      check("wrap_pd1", 32'(alloc_pd_1), (k == 0) ? 32'd50 : 32'(k));
      check("wrap_v1", 32'(alloc_valid_1), 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    check("wrap_count", 32'(count), 1);
    check("wrap_pd1_end", 32'(alloc_pd_1), 40);
    tick();

    // Free of p0 ignored, on either slot
    drive(0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("p0_count", 32'(count), 1);
    tick();
    drive(0, 0, 1, 0, 1, 5);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("p0_slot2_count", 32'(count), 2);
    check("p0_slot2_pd1", 32'(alloc_pd_1), 40);
    check("p0_slot2_pd2", 32'(alloc_pd_2), 5);
    tick();

    // Overflow: fill to DEPTH, extra push dropped, count saturates
    for (int i = 0; i < 15; i++) begin
      drive(0, 0, 1, 6'(6 + 2 * i), 1, 6'(7 + 2 * i));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    check("full_count", 32'(count), 32);
    tick();
    drive(0, 0, 1, 60, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("ovf_count", 32'(count), 32);
    check("ovf_pd1", 32'(alloc_pd_1), 40);
    tick();
    drive(1, 0, 1, 61, 0, 0);
    check("full_popush_pd1", 32'(alloc_pd_1), 40);
    check("full_popush_v1", 32'(alloc_valid_1), 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("full_popush_count", 32'(count), 32);
    check("full_popush_pd1n", 32'(alloc_pd_1), 5);
`ifdef FREE_LIST_CHECK_EN
    check("err_sticky_ovf", 32'(err_double_free), 1);
`endif
    tick();

    // Asynchronous reset in mid-cycle with traffic in flight
    drive(1, 1, 0, 0, 0, 0);
    tick();
    drive(1, 1, 1, 9, 0, 0);
    rst = 1'b1;
    #1;
    check("arst_pd1", 32'(alloc_pd_1), 32);
    check("arst_pd2", 32'(alloc_pd_2), 33);
    check("arst_count", 32'(count), 32);
`ifdef FREE_LIST_CHECK_EN
    check("arst_err", 32'(err_double_free), 0);
`endif
    alloc_req_1 = 1'b0; alloc_req_2 = 1'b0; free_valid_1 = 1'b0;
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    check("post_rst_stall", 32'(stall), 0);
    check("post_rst_count", 32'(count), 32);
    check("post_rst_pd1", 32'(alloc_pd_1), 32);
    tick();

    // Free p35 while already free: dropped at full, flag is sticky
    drive(0, 0, 1, 35, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("dbl_count", 32'(count), 32);
    check("dbl_pd1", 32'(alloc_pd_1), 32);
`ifdef FREE_LIST_CHECK_EN
    check("dbl_err", 32'(err_double_free), 1);
`endif
    tick();
    drive(1, 1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("dbl_after_count", 32'(count), 30);
`ifdef FREE_LIST_CHECK_EN
    check("dbl_err_hold", 32'(err_double_free), 1);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
